// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier:
// the FSM state type and the supported operand width range.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mult_state_t;

    localparam int unsigned MULT_W_MIN = 2;
    localparam int unsigned MULT_W_MAX = 64;

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration: conditionally adds the multiplicand,
// shifted left by the iteration index, into the running accumulator.
module mult_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0]         acc_i,
    input  logic [WIDTH-1:0]           mb_i,
    input  logic [$clog2(WIDTH)-1:0]   cnt_i,
    input  logic                       ma_bit_i,
    output logic [2*WIDTH-1:0]         acc_o
);

    logic [2*WIDTH-1:0] addend;

    always_comb begin
        addend = {{WIDTH{1'b0}}, mb_i} << cnt_i;
        acc_o  = ma_bit_i ? (acc_i + addend) : acc_i;
    end

endmodule

// File: rtl/seq_mult.sv
// Parametrised sequential multiplier with start/busy/done handshake,
// signed/unsigned mode and a result-fits-in-WIDTH (ovf) flag.
module seq_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ovf
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < MULT_W_MIN || WIDTH > MULT_W_MAX) begin : g_width_check
        $error("seq_mult: WIDTH must lie in 2..64");
    end

    mult_state_t        state_q, state_d;
    logic [WIDTH-1:0]   ma_q, ma_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic               neg_q, neg_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic               ovf_fix;

    // Unsigned WIDTH-bit magnitudes: |-2^(WIDTH-1)| wraps to 2^(WIDTH-1) exactly.
    always_comb begin
        mag_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        mag_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    end

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i    (acc_q),
        .mb_i     (mb_q),
        .cnt_i    (cnt_q),
        .ma_bit_i (ma_q[cnt_q]),
        .acc_o    (acc_step)
    );

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        if (sgn_q) begin
            ovf_fix = !((&prod_fix[2*WIDTH-1:WIDTH-1]) || !(|prod_fix[2*WIDTH-1:WIDTH-1]));
        end else begin
            ovf_fix = |prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        neg_d   = neg_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        prod_d  = prod_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ma_d    = mag_a;
                    mb_d    = mag_b;
                    neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    sgn_d   = is_signed;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                prod_d  = prod_fix;
                ovf_d   = ovf_fix;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            neg_q   <= neg_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: four instances (WIDTH 2, 8, 32, 64)
// checked against an arithmetic reference model.
module tb_seq_mult;

    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        st [NW];
    logic        sg [NW];
    logic [63:0] a  [NW];
    logic [63:0] b  [NW];
    logic        bz [NW];
    logic        dn [NW];
    logic        ov [NW];
    logic [127:0] pr [NW];

    logic [3:0]   p2;
    logic [15:0]  p8;
    logic [63:0]  p32;
    logic [127:0] p64;

    assign pr[0] = 128'(p2);
    assign pr[1] = 128'(p8);
    assign pr[2] = 128'(p32);
    assign pr[3] = p64;

    int wof [NW] = '{2, 8, 32, 64};
    int n_chk  = 0;
    int n_fail = 0;

    seq_mult #(.WIDTH(2)) u_w2 (
        .clk(clk), .reset_n(rst_n), .start(st[0]), .is_signed(sg[0]),
        .op_a(a[0][1:0]), .op_b(b[0][1:0]),
        .busy(bz[0]), .done(dn[0]), .product(p2), .ovf(ov[0])
    );
    seq_mult #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset_n(rst_n), .start(st[1]), .is_signed(sg[1]),
        .op_a(a[1][7:0]), .op_b(b[1][7:0]),
        .busy(bz[1]), .done(dn[1]), .product(p8), .ovf(ov[1])
    );
    seq_mult #(.WIDTH(32)) u_w32 (
        .clk(clk), .reset_n(rst_n), .start(st[2]), .is_signed(sg[2]),
        .op_a(a[2][31:0]), .op_b(b[2][31:0]),
        .busy(bz[2]), .done(dn[2]), .product(p32), .ovf(ov[2])
    );
    seq_mult #(.WIDTH(64)) u_w64 (
        .clk(clk), .reset_n(rst_n), .start(st[3]), .is_signed(sg[3]),
        .op_a(a[3]), .op_b(b[3]),
        .busy(bz[3]), .done(dn[3]), .product(p64), .ovf(ov[3])
    );

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // True integer product, reduced to 2*w bits; ovf when it leaves the w-bit range.
    task automatic model(int w, bit sgn, logic [63:0] av, logic [63:0] bv,
                         output logic [127:0] p, output logic o);
        logic [127:0] ua, ub, up, mask;
        logic signed [127:0] sa, sb, sp, lim;
        ua   = 128'(av);
        ub   = 128'(bv);
        mask = (w == 64) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
        if (sgn) begin
            sa = $signed(ua);
            sb = $signed(ub);
            if (av[w-1]) sa = sa - (128'sd1 <<< w);
            if (bv[w-1]) sb = sb - (128'sd1 <<< w);
            sp  = sa * sb;
            lim = 128'sd1 <<< (w - 1);
            p   = 128'(sp) & mask;
            o   = (sp >= lim) || (sp < -lim);
        end else begin
            up = ua * ub;
            p  = up & mask;
            o  = (up >> w) != 128'd0;
        end
    endtask

    task automatic run_op(int idx, bit sgn, logic [63:0] av_in, logic [63:0] bv_in, string tag,
                          output logic [127:0] po, output logic oo);
        int w;
        int n;
        logic [63:0] m, av, bv;
        logic [127:0] ep;
        logic eo;
        w  = wof[idx];
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        av = av_in & m;
        bv = bv_in & m;
        model(w, sgn, av, bv, ep, eo);
        @(negedge clk);
        st[idx] = 1'b1; sg[idx] = sgn; a[idx] = av; b[idx] = bv;
        @(posedge clk);
        @(negedge clk);
        st[idx] = 1'b0; sg[idx] = ~sgn; a[idx] = ~av; b[idx] = ~bv;
        check($sformatf("%s busy", tag), 128'(bz[idx]), 128'd1);
        n = 0;
        while (dn[idx] !== 1'b1 && n < w + 4) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check($sformatf("%s latency", tag), 128'(n), 128'(w + 1));
        check($sformatf("%s busy_at_done", tag), 128'(bz[idx]), 128'd0);
        check($sformatf("%s product", tag), pr[idx], ep);
        check($sformatf("%s ovf", tag), 128'(ov[idx]), 128'(eo));
        po = pr[idx];
        oo = ov[idx];
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s done_pulse", tag), 128'(dn[idx]), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] po;
        logic oo;
        int n;
        int cnt;
        logic [127:0] first_p;

        for (int i = 0; i < NW; i++) begin
            st[i] = 1'b0; sg[i] = 1'b0; a[i] = '0; b[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NW; i++) begin
            check($sformatf("reset busy w%0d", wof[i]), 128'(bz[i]), 128'd0);
            check($sformatf("reset done w%0d", wof[i]), 128'(dn[i]), 128'd0);
            check($sformatf("reset product w%0d", wof[i]), pr[i], 128'd0);
            check($sformatf("reset ovf w%0d", wof[i]), 128'(ov[i]), 128'd0);
        end
        rst_n = 1'b1;

        run_op(2, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "u32 max", po, oo);
        check("u32 max const", po, 128'hFFFF_FFFE_0000_0001);
        check("u32 max ovf const", 128'(oo), 128'd1);

        run_op(1, 1'b1, 64'h80, 64'h80, "s8 min*min", po, oo);
        check("s8 min*min const", po, 128'h4000);
        check("s8 min*min ovf const", 128'(oo), 128'd1);
        run_op(1, 1'b1, 64'hFD, 64'h05, "s8 -3*5", po, oo);
        check("s8 -3*5 const", po, 128'hFFF1);
        check("s8 -3*5 ovf const", 128'(oo), 128'd0);
        run_op(1, 1'b0, 64'hFD, 64'h05, "u8 253*5", po, oo);
        check("u8 253*5 const", po, 128'h04F1);
        check("u8 253*5 ovf const", 128'(oo), 128'd1);

        // Extra start pulses while busy must be ignored.
        @(negedge clk);
        st[1] = 1'b1; sg[1] = 1'b0; a[1] = 64'd200; b[1] = 64'd100;
        @(posedge clk);
        @(negedge clk);
        st[1] = 1'b0;
        cnt = 0;
        first_p = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            st[1] = (c == 3 || c == 6);
            if (c == 3 || c == 6) begin
                a[1] = 64'd5; b[1] = 64'd5;
            end
            if (dn[1] === 1'b1) begin
                cnt++;
                if (cnt == 1) first_p = pr[1];
            end
        end
        check("hs single done", 128'(cnt), 128'd1);
        check("hs product", first_p, 128'h4E20);
        check("hs idle after", 128'(bz[1]), 128'd0);

        // Start held through the done cycle: next operation follows with no gap.
        @(negedge clk);
        st[1] = 1'b1; sg[1] = 1'b1; a[1] = 64'hFD; b[1] = 64'h05;
        @(posedge clk);
        @(negedge clk);
        a[1] = 64'h80; b[1] = 64'h80;
        n = 0;
        while (dn[1] !== 1'b1 && n < 12) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("b2b first latency", 128'(n), 128'd9);
        check("b2b first product", pr[1], 128'hFFF1);
        check("b2b first ovf", 128'(ov[1]), 128'd0);
        @(posedge clk);
        @(negedge clk);
        st[1] = 1'b0;
        check("b2b busy no gap", 128'(bz[1]), 128'd1);
        check("b2b done drop", 128'(dn[1]), 128'd0);
        n = 0;
        while (dn[1] !== 1'b1 && n < 12) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("b2b second latency", 128'(n), 128'd9);
        check("b2b second product", pr[1], 128'h4000);
        check("b2b second ovf", 128'(ov[1]), 128'd1);

        // Asynchronous reset mid-CALC on the 32-bit instance.
        @(negedge clk);
        st[2] = 1'b1; sg[2] = 1'b0; a[2] = 64'd123456; b[2] = 64'd789;
        @(posedge clk);
        @(negedge clk);
        st[2] = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 128'(bz[2]), 128'd0);
        check("abort done", 128'(dn[2]), 128'd0);
        check("abort product", pr[2], 128'd0);
        check("abort ovf", 128'(ov[2]), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dn[2] === 1'b1 || bz[2] === 1'b1) cnt++;
        end
        check("abort no done", 128'(cnt), 128'd0);
        run_op(2, 1'b0, 64'd7, 64'd6, "u32 7*6", po, oo);
        check("u32 7*6 const", po, 128'd42);

        for (int i = 0; i < NW; i++) begin
            for (int k = 0; k < 12; k++) begin
                logic [63:0] ra, rb;
                bit rs;
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rs = bit'($urandom_range(1, 0));
                if (k == 0) begin ra = '1; rb = '1; end
                if (k == 1) begin ra = 64'd1 << (wof[i] - 1); rb = ra; end
                if (k == 2) ra = '0;
                run_op(i, rs, ra, rb, $sformatf("rnd w%0d #%0d s%0d", wof[i], k, rs), po, oo);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
